// File: rtl/network_trigger_controller_pkg.sv
// Purpose: shared type definitions for the actor trigger instances and the network controller.
// Latency: none; types and constants only.
// Backpressure: not applicable.
package TriggerTypes;

    // State of an individual actor trigger instance.
    typedef enum logic [2:0] {
        TRIG_IDLE       = 3'd0,
        TRIG_LAUNCH     = 3'd1,
        TRIG_CHECK      = 3'd2,
        TRIG_SLEEP      = 3'd3,
        TRIG_SYNC_LAUNCH= 3'd4,
        TRIG_SYNC_CHECK = 3'd5,
        TRIG_SYNC_WAIT  = 3'd6,
        TRIG_SYNC_EXEC  = 3'd7
    } trigger_state_t;

    // Return code produced by an actor invocation.
    typedef enum logic [1:0] {
        RET_IDLE      = 2'd0,
        RET_WAIT_INPUT= 2'd1,
        RET_WAIT_OUTPUT=2'd2,
        RET_EXECUTED  = 2'd3
    } trigger_ret_t;

    // Network-level sequencer state.
    typedef enum logic [1:0] {
        NET_IDLE  = 2'd0,
        NET_START = 2'd1,
        NET_RUN   = 2'd2,
        NET_DONE  = 2'd3
    } net_state_t;

    localparam logic [15:0] SYNC_ROUNDS_MAX = 16'hFFFF;

endpackage

// File: rtl/network_trigger_controller_status_reduce.sv
// Purpose: registered AND-reductions of per-trigger status flags plus leave-one-out waited vector.
// Latency: exactly one cycle from input flags to outputs.
// Backpressure: none; samples every cycle.
// Ports: ap_clk/ap_rst (sync, active-high); trig_* per-trigger flags in; all_* broadcasts out.
module trigger_status_reduce #(
    parameter int NUM_ACTORS = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [NUM_ACTORS-1:0] trig_sleep,
    input  logic [NUM_ACTORS-1:0] trig_sync_exec,
    input  logic [NUM_ACTORS-1:0] trig_sync_wait,
    input  logic [NUM_ACTORS-1:0] trig_waited,
    output logic                  all_sleep,
    output logic                  all_sync,
    output logic                  all_sync_wait,
    output logic [NUM_ACTORS-1:0] all_waited
);

    logic [NUM_ACTORS-1:0] waited_loo;

    // Bit i ignores trigger i's own flag by forcing that bit to 1 before the AND.
    always_comb begin
        waited_loo = '0;
        for (int i = 0; i < NUM_ACTORS; i++) begin
            waited_loo[i] = &(trig_waited | (NUM_ACTORS'(1) << i));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            all_sleep     <= 1'b0;
            all_sync      <= 1'b0;
            all_sync_wait <= 1'b0;
            all_waited    <= '0;
        end else begin
            all_sleep     <= &trig_sleep;
            all_sync      <= &(trig_sync_exec | trig_sync_wait);
            all_sync_wait <= &trig_sync_wait;
            all_waited    <= waited_loo;
        end
    end

endmodule

// File: rtl/network_trigger_controller.sv
// Purpose: network ap_start/ap_done sequencer launching all actor triggers, with enqueue tracking.
// Latency: trig_start one cycle after ap_start; ap_done QUIESCE_CYCLES+1 cycles after first all-idle cycle.
// Backpressure: ap_start ignored outside IDLE; completion held off while any enqueue is pending.
// Ports: ap_* network handshake; trig_* per-trigger control/status; in_fifo_write enqueue strobes;
//        external_enqueue, all_* broadcasts and sync_rounds counter out.
module network_trigger_controller
    import TriggerTypes::*;
#(
    parameter int NUM_ACTORS     = 4,
    parameter int NUM_INPUTS     = 2,
    parameter int QUIESCE_CYCLES = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [NUM_ACTORS-1:0] trig_start,
    input  logic [NUM_ACTORS-1:0] trig_idle,
    input  logic [NUM_ACTORS-1:0] trig_sleep,
    input  logic [NUM_ACTORS-1:0] trig_sync_exec,
    input  logic [NUM_ACTORS-1:0] trig_sync_wait,
    input  logic [NUM_ACTORS-1:0] trig_waited,
    input  logic [NUM_INPUTS-1:0] in_fifo_write,
    output logic                  external_enqueue,
    output logic                  all_sleep,
    output logic                  all_sync,
    output logic                  all_sync_wait,
    output logic [NUM_ACTORS-1:0] all_waited,
    output logic [15:0]           sync_rounds
);

    localparam int CW = $clog2(QUIESCE_CYCLES + 1);
    localparam logic [CW-1:0] QUIESCE_MAX = CW'(QUIESCE_CYCLES);

    net_state_t    state;
    logic [CW-1:0] quiesce_cnt;
    logic          enq_pending;
    logic          all_sync_d;

    logic all_idle, any_write, quiet, idle_to_start, relaunch, enter_start;

    assign all_idle      = &trig_idle;
    assign any_write     = |in_fifo_write;
    assign quiet         = all_idle & ~enq_pending;
    assign idle_to_start = (state == NET_IDLE) & ap_start;
    assign relaunch      = (state == NET_RUN) & all_idle & enq_pending;
    assign enter_start   = idle_to_start | relaunch;

    assign ap_ready         = ap_done;
    assign external_enqueue = enq_pending;

    trigger_status_reduce #(
        .NUM_ACTORS (NUM_ACTORS)
    ) u_reduce (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .trig_sleep     (trig_sleep),
        .trig_sync_exec (trig_sync_exec),
        .trig_sync_wait (trig_sync_wait),
        .trig_waited    (trig_waited),
        .all_sleep      (all_sleep),
        .all_sync       (all_sync),
        .all_sync_wait  (all_sync_wait),
        .all_waited     (all_waited)
    );

    // Sequencer with registered outputs. The quiescence counter saturates at its target so
    // a same-cycle enqueue can hold off DONE for one cycle and then force a relaunch.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= NET_IDLE;
            ap_idle     <= 1'b1;
            ap_done     <= 1'b0;
            trig_start  <= '0;
            quiesce_cnt <= '0;
        end else begin
            ap_idle    <= 1'b0;
            ap_done    <= 1'b0;
            trig_start <= '0;
            case (state)
                NET_IDLE: begin
                    if (ap_start) begin
                        state      <= NET_START;
                        trig_start <= '1;
                    end else begin
                        ap_idle    <= 1'b1;
                    end
                end
                NET_START: begin
                    state       <= NET_RUN;
                    quiesce_cnt <= '0;
                end
                NET_RUN: begin
                    if (quiet)
                        quiesce_cnt <= (quiesce_cnt == QUIESCE_MAX) ? quiesce_cnt : quiesce_cnt + 1'b1;
                    else
                        quiesce_cnt <= '0;
                    if (relaunch) begin
                        state      <= NET_START;
                        trig_start <= '1;
                    end else if (quiesce_cnt == QUIESCE_MAX && quiet && !any_write) begin
                        state   <= NET_DONE;
                        ap_done <= 1'b1;
                    end
                end
                NET_DONE: begin
                    state   <= NET_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= NET_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

    // Enqueue tracking: a write always wins over either clear source.
    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            enq_pending <= 1'b0;
        else if (any_write)
            enq_pending <= 1'b1;
        else if (all_sleep || enter_start)
            enq_pending <= 1'b0;
    end

    // Count rising edges of the registered all_sync; a fresh run starts from zero.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            all_sync_d  <= 1'b0;
            sync_rounds <= '0;
        end else begin
            all_sync_d <= all_sync;
            if (idle_to_start)
                sync_rounds <= '0;
            else if (all_sync && !all_sync_d && sync_rounds != SYNC_ROUNDS_MAX)
                sync_rounds <= sync_rounds + 16'd1;
        end
    end

endmodule

// File: tb/tb_network_trigger_controller.sv
module tb_network_trigger_controller;

    localparam int NA = 4;
    localparam int NI = 2;
    localparam int QC = 2;

    localparam int S_IDLE = 0, S_START = 1, S_RUN = 2, S_DONE = 3;

    typedef struct packed {
        logic          ap_done;
        logic          ap_ready;
        logic          ap_idle;
        logic [NA-1:0] trig_start;
        logic          external_enqueue;
        logic          all_sleep;
        logic          all_sync;
        logic          all_sync_wait;
        logic [NA-1:0] all_waited;
        logic [15:0]   sync_rounds;
    } obs_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst, ap_start;
    logic          ap_done, ap_ready, ap_idle;
    logic [NA-1:0] trig_start, trig_idle, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited;
    logic [NI-1:0] in_fifo_write;
    logic          external_enqueue, all_sleep, all_sync, all_sync_wait;
    logic [NA-1:0] all_waited;
    logic [15:0]   sync_rounds;

    always #5 ap_clk = ~ap_clk;

    network_trigger_controller #(
        .NUM_ACTORS(NA), .NUM_INPUTS(NI), .QUIESCE_CYCLES(QC)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .trig_start(trig_start), .trig_idle(trig_idle), .trig_sleep(trig_sleep),
        .trig_sync_exec(trig_sync_exec), .trig_sync_wait(trig_sync_wait),
        .trig_waited(trig_waited), .in_fifo_write(in_fifo_write),
        .external_enqueue(external_enqueue), .all_sleep(all_sleep), .all_sync(all_sync),
        .all_sync_wait(all_sync_wait), .all_waited(all_waited), .sync_rounds(sync_rounds)
    );

    // Stimulus for the next cycle.
    logic          s_rst, s_start;
    logic [NA-1:0] s_idle, s_sleep, s_exec, s_wait, s_waited;
    logic [NI-1:0] s_wr;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   driver_done = 0;

    // Reference model: state as seen during the current cycle.
    int          m_st;
    int          m_quiet_run;     // consecutive quiet RUN cycles already seen
    bit          m_pend;
    bit          m_sleep, m_sync, m_syncw, m_prev_sync;
    bit [NA-1:0] m_waited;
    int          m_rounds;

    function automatic obs_t model_obs();
        obs_t o;
        o.ap_done          = (m_st == S_DONE);
        o.ap_ready         = (m_st == S_DONE);
        o.ap_idle          = (m_st == S_IDLE);
        o.trig_start       = (m_st == S_START) ? {NA{1'b1}} : {NA{1'b0}};
        o.external_enqueue = m_pend;
        o.all_sleep        = m_sleep;
        o.all_sync         = m_sync;
        o.all_sync_wait    = m_syncw;
        o.all_waited       = m_waited;
        o.sync_rounds      = m_rounds[15:0];
        return o;
    endfunction

    // Advance the model across one clock edge using the stimulus about to be applied.
    task automatic model_step();
        bit          all_idle, wr, from_idle, relaunch, go_done, rising;
        int          nst, zeros;
        bit [NA-1:0] nw;
        if (s_rst) begin
            m_st = S_IDLE; m_quiet_run = 0; m_pend = 0;
            m_sleep = 0; m_sync = 0; m_syncw = 0; m_prev_sync = 0;
            m_waited = '0; m_rounds = 0;
            return;
        end
        all_idle  = ($countones(s_idle) == NA);
        wr        = (s_wr != '0);
        from_idle = (m_st == S_IDLE) && s_start;
        relaunch  = (m_st == S_RUN) && all_idle && m_pend;
        go_done   = (m_st == S_RUN) && !relaunch && (m_quiet_run >= QC) && all_idle && !m_pend && !wr;
        case (m_st)
            S_IDLE:  nst = s_start ? S_START : S_IDLE;
            S_START: nst = S_RUN;
            S_RUN:   nst = relaunch ? S_START : (go_done ? S_DONE : S_RUN);
            default: nst = S_IDLE;
        endcase
        if (m_st == S_RUN && all_idle && !m_pend)
            m_quiet_run = (m_quiet_run >= QC) ? QC : m_quiet_run + 1;
        else
            m_quiet_run = 0;
        rising = m_sync && !m_prev_sync;
        if (from_idle)
            m_rounds = 0;
        else if (rising && m_rounds < 16'hFFFF)
            m_rounds = m_rounds + 1;
        m_prev_sync = m_sync;
        if (wr)
            m_pend = 1;
        else if (m_sleep || from_idle || relaunch)
            m_pend = 0;
        for (int i = 0; i < NA; i++) begin
            zeros = 0;
            for (int j = 0; j < NA; j++)
                if (j != i && !s_waited[j]) zeros++;
            nw[i] = (zeros == 0);
        end
        m_waited = nw;
        m_sleep  = ($countones(s_sleep) == NA);
        m_syncw  = ($countones(s_wait) == NA);
        m_sync   = ($countones(s_exec | s_wait) == NA);
        m_st     = nst;
    endtask

    task automatic apply_and_push();
        ap_rst = s_rst; ap_start = s_start; trig_idle = s_idle; trig_sleep = s_sleep;
        trig_sync_exec = s_exec; trig_sync_wait = s_wait; trig_waited = s_waited;
        in_fifo_write = s_wr;
        model_step();
        exp_q.push_back(model_obs());
    endtask

    task automatic step();
        @(negedge ap_clk);
        apply_and_push();
    endtask

    task automatic quiet_stim();
        s_rst = 0; s_start = 0; s_idle = '0; s_sleep = '0; s_exec = '0; s_wait = '0;
        s_waited = '0; s_wr = '0;
    endtask

    task automatic random_stim();
        s_rst   = ($urandom_range(199) == 0);
        s_start = ($urandom_range(2) == 0);
        s_idle  = ($urandom_range(3) != 0) ? {NA{1'b1}} : NA'($urandom);
        s_sleep = ($urandom_range(5) == 0) ? {NA{1'b1}} : NA'($urandom);
        s_exec  = NA'($urandom);
        s_wait  = ($urandom_range(1) == 0) ? ~s_exec : NA'($urandom);
        if ($urandom_range(5) == 0) s_wait = {NA{1'b1}};
        s_waited = ($urandom_range(1) == 0) ? ~(NA'(1) << $urandom_range(NA-1)) : NA'($urandom);
        if ($urandom_range(4) == 0) s_waited = {NA{1'b1}};
        s_wr    = ($urandom_range(24) == 0) ? NI'($urandom_range(3, 1)) : '0;
    endtask

    // Monitor: every cycle the DUT presents its full output set, one expectation is popped.
    always @(posedge ap_clk) begin
        obs_t e, a;
        bit   bad;
        #1;
        a = '{ap_done, ap_ready, ap_idle, trig_start, external_enqueue, all_sleep,
              all_sync, all_sync_wait, all_waited, sync_rounds};
        if (exp_q.size() == 0) begin
            if (!driver_done) begin
                vectors++; miscompares++;
                $display("FAIL no_expectation t=%0t", $time);
            end
        end else begin
            e = exp_q.pop_front();
            vectors++;
            bad = 0;
            if (a.ap_done !== e.ap_done) begin bad = 1; $display("FAIL ap_done t=%0t got %b want %b", $time, a.ap_done, e.ap_done); end
            if (a.ap_ready !== e.ap_ready) begin bad = 1; $display("FAIL ap_ready t=%0t got %b want %b", $time, a.ap_ready, e.ap_ready); end
            if (a.ap_idle !== e.ap_idle) begin bad = 1; $display("FAIL ap_idle t=%0t got %b want %b", $time, a.ap_idle, e.ap_idle); end
            if (a.trig_start !== e.trig_start) begin bad = 1; $display("FAIL trig_start t=%0t got %h want %h", $time, a.trig_start, e.trig_start); end
            if (a.external_enqueue !== e.external_enqueue) begin bad = 1; $display("FAIL external_enqueue t=%0t got %b want %b", $time, a.external_enqueue, e.external_enqueue); end
            if (a.all_sleep !== e.all_sleep) begin bad = 1; $display("FAIL all_sleep t=%0t got %b want %b", $time, a.all_sleep, e.all_sleep); end
            if (a.all_sync !== e.all_sync) begin bad = 1; $display("FAIL all_sync t=%0t got %b want %b", $time, a.all_sync, e.all_sync); end
            if (a.all_sync_wait !== e.all_sync_wait) begin bad = 1; $display("FAIL all_sync_wait t=%0t got %b want %b", $time, a.all_sync_wait, e.all_sync_wait); end
            if (a.all_waited !== e.all_waited) begin bad = 1; $display("FAIL all_waited t=%0t got %b want %b", $time, a.all_waited, e.all_waited); end
            if (a.sync_rounds !== e.sync_rounds) begin bad = 1; $display("FAIL sync_rounds t=%0t got %0d want %0d", $time, a.sync_rounds, e.sync_rounds); end
            if (bad) miscompares++;
        end
    end

    initial begin
        // Reset applied before the first edge.
        quiet_stim();
        s_rst = 1;
        apply_and_push();
        step();
        s_rst = 0;
        step();

        // Start pulse, then all triggers idle until completion.
        s_start = 1; step();
        s_start = 0; s_idle = '1;
        repeat (6) step();

        // Leave-one-out waited patterns and mixed sync flags with three rising edges.
        s_waited = 4'b0111; step();
        s_waited = 4'b1111; step();
        s_start = 1; s_idle = '0; step();
        s_start = 0;
        repeat (3) begin
            s_exec = 4'b0011; s_wait = 4'b1100; step();
            s_exec = 4'b0000; s_wait = 4'b0000; step();
        end
        // Enqueue while idle in RUN forces a relaunch instead of completion.
        s_idle = '1; s_wr = 2'b01; step();
        s_wr = '0; repeat (3) step();
        // Write coinciding with registered all_sleep: pending must survive.
        s_sleep = '1; step();
        s_wr = 2'b10; step();
        s_wr = '0; s_sleep = '0; repeat (6) step();
        // Reset in the middle of a run.
        s_start = 1; s_idle = '0; step();
        s_start = 0; repeat (3) step();
        s_rst = 1; step();
        s_rst = 0; repeat (2) step();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            random_stim();
            step();
        end

        @(posedge ap_clk);
        #2;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge ap_clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left %0d want 0", exp_q.size());
        end
        driver_done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
